// File: rtl/memory_access_unit.sv
// memory_access_unit: memory-stage load/store sequencer for RV32.
// Drives a req/ready data port, stalls the pipe, flags bad accesses.
module memory_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  input  logic [2:0]            MemoryOp_i,
  input  logic [DATA_WIDTH-1:0] ALUResult_i,
  input  logic [DATA_WIDTH-1:0] WriteData_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] ReadData_o,
  output logic                  stall_o,
  output logic                  misaligned_o,
  output logic                  bus_error_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [2:0]      op_q, op_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            mis_q, mis_d;
  logic            err_q, err_d;

  logic            access;
  logic [1:0]      a;
  logic            op_bad;
  logic            misal;
  logic [3:0]      be_n;
  logic [31:0]     wd_n;
  logic [31:0]     sh_b;
  logic [31:0]     sh_h;
  logic [31:0]     ld;
  logic            stall_c;
  logic            busy;

  // Decode legality and store lane placement of the incoming access
  always_comb begin
    access = MemRead_i | MemWrite_i;
    a      = ALUResult_i[1:0];
    op_bad = (MemoryOp_i == 3'b011) |
             (MemoryOp_i == 3'b110) |
             (MemoryOp_i == 3'b111) |
             (MemWrite_i & MemoryOp_i[2]);
    misal  = ((MemoryOp_i[1:0] == 2'b01) & a[0]) |
             ((MemoryOp_i == OP_W) & (a != 2'b00));
    be_n   = 4'b1111;
    wd_n   = 32'h0;
    unique case (1'b1)
      (MemWrite_i & (MemoryOp_i[1:0] == 2'b00)): begin
        be_n = 4'b0001 << a;
        wd_n = {4{WriteData_i[7:0]}};
      end
      (MemWrite_i & (MemoryOp_i[1:0] == 2'b01)): begin
        be_n = a[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{WriteData_i[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = MemWrite_i ? WriteData_i : 32'h0;
      end
    endcase
  end

  // Select and extend the addressed lane of the returned word
  always_comb begin
    sh_b = mem_rdata_i >> {off_q, 3'b000};
    sh_h = mem_rdata_i >> {off_q[1], 4'b0000};
    ld   = mem_rdata_i;
    unique case (op_q)
      OP_B:    ld = {{24{sh_b[7]}}, sh_b[7:0]};
      OP_BU:   ld = {24'h0, sh_b[7:0]};
      OP_H:    ld = {{16{sh_h[15]}}, sh_h[15:0]};
      OP_HU:   ld = {16'h0, sh_h[15:0]};
      default: ld = mem_rdata_i;
    endcase
  end

  // Next-state, request capture, timeout and pulse generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    op_d    = op_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    stall_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = 32'h0;
        if (access) begin
          if (op_bad) begin
            err_d = 1'b1;
          end else if (misal) begin
            mis_d = 1'b1;
          end else begin
            stall_c = 1'b1;
            we_d    = MemWrite_i;
            addr_d  = {ALUResult_i[31:2], 2'b00};
            be_d    = be_n;
            wdata_d = wd_n;
            op_d    = MemoryOp_i;
            off_d   = a;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 32'h1;
        if (mem_ready_i) begin
          if (!we_q) rdata_d = ld;
          cnt_d   = 32'h0;
          state_d = DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST)) begin
          err_d   = 1'b1;
          rdata_d = 32'h0;
          cnt_d   = 32'h0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 32'h0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      op_q    <= 3'b0;
      off_q   <= 2'b0;
      rdata_q <= 32'h0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      op_q    <= op_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  // Port drive; request fields are only shown while a request is live
  always_comb begin
    busy         = (state_q == BUSY);
    mem_req_o    = busy;
    mem_we_o     = busy & we_q;
    mem_addr_o   = busy ? addr_q : 32'h0;
    mem_be_o     = busy ? be_q : 4'h0;
    mem_wdata_o  = busy ? wdata_q : 32'h0;
    ReadData_o   = rdata_q;
    stall_o      = rst_n & stall_c;
    misaligned_o = mis_q;
    bus_error_o  = err_q;
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// tb_memory_access_unit: directed checks of the memory access unit.
// Drives accesses, plays the memory side, compares fixed expectations.
module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [2:0]  MemoryOp_i;
  logic [31:0] ALUResult_i;
  logic [31:0] WriteData_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ready_i;
  logic [31:0] mem_rdata_i;
  logic [31:0] ReadData_o;
  logic        stall_o;
  logic        misaligned_o;
  logic        bus_error_o;

  memory_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i),
    .MemoryOp_i(MemoryOp_i),
    .ALUResult_i(ALUResult_i),
    .WriteData_i(WriteData_i),
    .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ready_i(mem_ready_i),
    .mem_rdata_i(mem_rdata_i),
    .ReadData_o(ReadData_o),
    .stall_o(stall_o),
    .misaligned_o(misaligned_o),
    .bus_error_o(bus_error_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int          n_stall;
  int          n_req;
  int          n_mis;
  int          n_err;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_we;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access from the pipeline; waits<0 means memory never answers
  task automatic run_acc(input logic rd, input logic wr,
                         input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int waits);
    logic done;
    done        = 1'b0;
    MemRead_i   = rd;
    MemWrite_i  = wr;
    MemoryOp_i  = op;
    ALUResult_i = addr;
    WriteData_i = wd;
    n_stall = 0;
    n_req   = 0;
    n_mis   = 0;
    n_err   = 0;
    r_addr  = 32'h0;
    r_wdata = 32'h0;
    r_be    = 4'h0;
    r_we    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stall_o) n_stall++;
      if (misaligned_o) n_mis++;
      if (bus_error_o) n_err++;
      if (mem_req_o) begin
        n_req++;
        if (n_req == 1) begin
          r_addr  = mem_addr_o;
          r_wdata = mem_wdata_o;
          r_be    = mem_be_o;
          r_we    = mem_we_o;
        end
      end
      mem_ready_i = mem_req_o && (n_req == waits + 1);
      mem_rdata_i = mem_ready_i ? rdat : 32'h0;
      done = !stall_o;
      @(posedge clk);
      #1;
      if (done) break;
    end
    chk("bound", 32'(done), 32'd1);
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    mem_ready_i = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (stall_o) n_stall++;
      if (misaligned_o) n_mis++;
      if (bus_error_o) n_err++;
      if (mem_req_o) n_req++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b0;
    MemoryOp_i  = 3'b000;
    ALUResult_i = 32'h0;
    WriteData_i = 32'h0;
    mem_ready_i = 1'b0;
    mem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk("rst_be", 32'(mem_be_o), 32'h0);
    chk("rst_rdata", ReadData_o, 32'h0);
    chk("rst_err", 32'(bus_error_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // LW with two wait states
    run_acc(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 2);
    chk("lw_stall", n_stall, 4);
    chk("lw_req", n_req, 3);
    chk("lw_addr", r_addr, 32'h100);
    chk("lw_be", 32'(r_be), 32'hF);
    chk("lw_we", 32'(r_we), 32'd0);
    chk("lw_data", ReadData_o, 32'hDEADBEEF);

    // SB to lane 3, zero-wait
    run_acc(1'b0, 1'b1, 3'b000, 32'h203, 32'hA5, 32'h0, 0);
    chk("sb_stall", n_stall, 2);
    chk("sb_we", 32'(r_we), 32'd1);
    chk("sb_be", 32'(r_be), 32'h8);
    chk("sb_wdata", r_wdata, 32'hA5A5A5A5);
    chk("sb_addr", r_addr, 32'h200);
    chk("sb_hold", ReadData_o, 32'hDEADBEEF);

    // Sub-word loads and extension
    run_acc(1'b1, 1'b0, 3'b000, 32'h2, 32'h0, 32'h0080FF00, 0);
    chk("lb", ReadData_o, 32'hFFFFFF80);
    run_acc(1'b1, 1'b0, 3'b100, 32'h2, 32'h0, 32'h0080FF00, 0);
    chk("lbu", ReadData_o, 32'h00000080);
    run_acc(1'b1, 1'b0, 3'b001, 32'h2, 32'h0, 32'h0080FF00, 1);
    chk("lh", ReadData_o, 32'h00000080);
    chk("lh_stall", n_stall, 3);
    run_acc(1'b1, 1'b0, 3'b101, 32'h0, 32'h0, 32'h0080FF00, 0);
    chk("lhu", ReadData_o, 32'h0000FF00);
    run_acc(1'b1, 1'b0, 3'b001, 32'h0, 32'h0, 32'h0000FF00, 0);
    chk("lh_neg", ReadData_o, 32'hFFFFFF00);

    // SH upper half; store wins over load
    run_acc(1'b1, 1'b1, 3'b001, 32'h2, 32'h1234BEEF, 32'h0, 0);
    chk("sh_be", 32'(r_be), 32'hC);
    chk("sh_wdata", r_wdata, 32'hBEEFBEEF);
    chk("sh_we", 32'(r_we), 32'd1);
    chk("sh_hold", ReadData_o, 32'hFFFFFF00);

    // Misaligned and illegal accesses
    run_acc(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0);
    chk("mis_pulse", n_mis, 1);
    chk("mis_req", n_req, 0);
    chk("mis_stall", n_stall, 0);
    chk("mis_err", n_err, 0);
    run_acc(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0);
    chk("ill_err", n_err, 1);
    chk("ill_req", n_req, 0);
    chk("ill_mis", n_mis, 0);
    run_acc(1'b0, 1'b1, 3'b101, 32'h1, 32'h0, 32'h0, 0);
    chk("ill_pri_err", n_err, 1);
    chk("ill_pri_mis", n_mis, 0);
    chk("ill_pri_req", n_req, 0);

    // Timeout abort
    run_acc(1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, -1);
    chk("to_req", n_req, 16);
    chk("to_stall", n_stall, 17);
    chk("to_err", n_err, 1);
    chk("to_data", ReadData_o, 32'h0);
    chk("to_idle", 32'(mem_req_o), 32'd0);

    // Reset in the 2nd BUSY cycle of an SW, then reissue
    MemRead_i   = 1'b0;
    MemWrite_i  = 1'b1;
    MemoryOp_i  = 3'b010;
    ALUResult_i = 32'h400;
    WriteData_i = 32'hCAFEF00D;
    @(negedge clk);
    chk("sw_idle_stall", 32'(stall_o), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("sw_busy2_req", 32'(mem_req_o), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req_o), 32'd0);
    chk("ar_stall", 32'(stall_o), 32'd0);
    chk("ar_addr", mem_addr_o, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_acc(1'b0, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0, 0);
    chk("re_stall", n_stall, 2);
    chk("re_addr", r_addr, 32'h400);
    chk("re_be", 32'(r_be), 32'hF);
    chk("re_wdata", r_wdata, 32'hCAFEF00D);
    chk("re_req", n_req, 1);
    chk("re_rdata", ReadData_o, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
